// File: rtl/shared_mem_interconnect.sv
// Round-robin interconnect: NUM_PORTS requesters onto a global spsram and a device window.
// Optional bus locking is compiled in with `define SHARED_MEM_LOCK_EN.
module shared_mem_interconnect #(
  parameter int NUM_PORTS       = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int GMEM_SIZE       = 1024,
  parameter int DEV_PREFIX_BITS = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_wren,
  input  logic [NUM_PORTS-1:0]             port_rden,
  input  logic [NUM_PORTS-1:0]             port_lock,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_grant,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [NUM_PORTS-1:0]             port_rvalid,
  output logic [DATA_WIDTH-1:0]            port_rdata,
  output logic [3:0]                       dev_core_id,
  output logic                             dev_wren,
  output logic                             dev_rden,
  output logic [ADDR_WIDTH-DEV_PREFIX_BITS-1:0] dev_addr,
  output logic [DATA_WIDTH-1:0]            dev_wdata,
  input  logic                             dev_ready,
  input  logic [DATA_WIDTH-1:0]            dev_rdata
);
  localparam int PW      = $clog2(NUM_PORTS);
  localparam int GMEM_AW = $clog2(GMEM_SIZE);
  localparam int DEV_AW  = ADDR_WIDTH - DEV_PREFIX_BITS;
  localparam logic [PW:0] NP_W = (PW+1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0]                 req;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_a;

  assign req     = port_wren | port_rden;
  assign addr_a  = port_addr;
  assign wdata_a = port_wdata;

  logic [PW-1:0]        rr_ptr, gnt_idx, cand, lock_owner;
  logic [PW:0]          sum;
  logic                 gnt_vld, locked;
  logic [NUM_PORTS-1:0] gnt_oh, rd_port;
  logic                 src_dev;

`ifdef SHARED_MEM_LOCK_EN
  logic lock_vld;
  assign locked = lock_vld & port_lock[lock_owner];
`else
  logic unused_lock;
  assign unused_lock = ^port_lock;
  assign locked      = 1'b0;
  assign lock_owner  = '0;
`endif

  // Locked owner keeps the grant even when idle; otherwise search from rr_ptr modulo NUM_PORTS.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    if (locked) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_owner;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, rr_ptr} + (PW+1)'(k);
        if (sum >= NP_W) sum = sum - NP_W;
        cand = sum[PW-1:0];
        if (!gnt_vld && req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_wr, sel_rd, dev_sel, ack_any;
  logic [GMEM_AW-1:0]    mem_addr;

  assign sel_addr  = addr_a[gnt_idx];
  assign sel_wdata = wdata_a[gnt_idx];
  // A simultaneous write+read request is a plain write.
  assign sel_wr    = gnt_vld & port_wren[gnt_idx];
  assign sel_rd    = gnt_vld & port_rden[gnt_idx] & ~port_wren[gnt_idx];
  assign dev_sel   = &sel_addr[ADDR_WIDTH-1 -: DEV_PREFIX_BITS];
  assign ack_any   = (sel_wr | sel_rd) & (~dev_sel | dev_ready);
  assign mem_addr  = sel_addr[GMEM_AW-1:0];
  assign gnt_oh    = NUM_PORTS'(gnt_vld) << gnt_idx;

  assign port_grant  = gnt_oh;
  assign port_ack    = ack_any ? gnt_oh : '0;
  assign dev_core_id = 4'(gnt_idx);
  assign dev_wren    = sel_wr & dev_sel;
  assign dev_rden    = sel_rd & dev_sel;
  assign dev_addr    = sel_addr[DEV_AW-1:0];
  assign dev_wdata   = sel_wdata;
  assign port_rvalid = rd_port;

  logic [DATA_WIDTH-1:0] mem [GMEM_SIZE];
  logic [DATA_WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (ack_any && !dev_sel) begin
      if (sel_wr) mem[mem_addr] <= sel_wdata;
      else        q             <= mem[mem_addr];
    end
  end

  assign port_rdata = src_dev ? dev_rdata : q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      rd_port <= '0;
      src_dev <= 1'b0;
    end else begin
      rd_port <= (ack_any && sel_rd) ? gnt_oh : '0;
      if (ack_any && sel_rd) src_dev <= dev_sel;
      if (ack_any) rr_ptr <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef SHARED_MEM_LOCK_EN
  // Dropping port_lock releases in the same cycle via 'locked'; the register just follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld   <= 1'b0;
      lock_owner <= '0;
    end else if (ack_any && port_lock[gnt_idx]) begin
      lock_vld   <= 1'b1;
      lock_owner <= gnt_idx;
    end else if (!locked) begin
      lock_vld   <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_shared_mem_interconnect.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_shared_mem_interconnect;
  localparam int NP = 8, DW = 16, AW = 16, DAW = 10;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]    port_wren, port_rden, port_lock;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_grant, port_ack, port_rvalid;
  logic [DW-1:0]    port_rdata;
  logic [3:0]       dev_core_id;
  logic             dev_wren, dev_rden;
  logic [DAW-1:0]   dev_addr;
  logic [DW-1:0]    dev_wdata;
  logic             dev_ready;
  logic [DW-1:0]    dev_rdata;

  shared_mem_interconnect dut (
    .clk(clk), .reset(reset),
    .port_wren(port_wren), .port_rden(port_rden), .port_lock(port_lock),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_grant(port_grant), .port_ack(port_ack), .port_rvalid(port_rvalid),
    .port_rdata(port_rdata), .dev_core_id(dev_core_id),
    .dev_wren(dev_wren), .dev_rden(dev_rden), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_ready(dev_ready), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rr_m = 0;
  logic [DW-1:0] mem_m [1024];

  task automatic clr;
    port_wren = '0; port_rden = '0; port_lock = '0;
    port_addr = '0; port_wdata = '0;
    dev_ready = 1'b1; dev_rdata = '0;
  endtask

  task automatic set_port(input int p, input bit w, input bit r,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    port_wren[p] = w;
    port_rden[p] = r;
    port_addr[p*AW +: AW]  = a;
    port_wdata[p*DW +: DW] = d;
  endtask

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; clr();
    next_cyc();
    reset = 1'b0; rr_m = 0;
  endtask

  task automatic test_reset;
    clr(); reset = 1'b1;
    #1;
    checks++; if (port_grant !== 8'h00) begin errors++; $display("FAIL reset grant: got %h want 00", port_grant); end
    checks++; if (port_rvalid !== 8'h00) begin errors++; $display("FAIL reset rvalid: got %h want 00", port_rvalid); end
    checks++; if ({dev_wren, dev_rden} !== 2'b00) begin errors++; $display("FAIL reset dev strobes: got %b want 00", {dev_wren, dev_rden}); end
    next_cyc(); reset = 1'b0; rr_m = 0;
    @(negedge clk);
    checks++; if (port_ack !== 8'h00) begin errors++; $display("FAIL reset ack idle: got %h want 00", port_ack); end
    next_cyc();
  endtask

  task automatic test_all_read;
    logic [NP-1:0] exp;
    for (int k = 0; k < NP; k++) begin
      set_port(0, 1, 0, 16'(k), 16'(k));
      next_cyc();
      mem_m[k] = 16'(k);
    end
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 0, 1, 16'(i), 16'h0);
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      exp = 8'(1) << i;
      checks++; if (port_grant !== exp) begin errors++; $display("FAIL all_read grant %0d: got %h want %h", i, port_grant, exp); end
      checks++; if (port_ack !== exp) begin errors++; $display("FAIL all_read ack %0d: got %h want %h", i, port_ack, exp); end
      if (i > 0) begin
        checks++; if (port_rvalid !== (exp >> 1)) begin errors++; $display("FAIL all_read rvalid %0d: got %h want %h", i-1, port_rvalid, exp >> 1); end
        checks++; if (port_rdata !== 16'(i-1)) begin errors++; $display("FAIL all_read rdata %0d: got %h want %h", i-1, port_rdata, 16'(i-1)); end
      end
      next_cyc();
      port_rden[i] = 1'b0;
    end
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h80) begin errors++; $display("FAIL all_read rvalid 7: got %h want 80", port_rvalid); end
    checks++; if (port_rdata !== 16'd7) begin errors++; $display("FAIL all_read rdata 7: got %h want 0007", port_rdata); end
    rr_m = 0;
    clr(); next_cyc();
  endtask

  task automatic test_alias;
    set_port(2, 1, 0, 16'h0010, 16'hBEEF);
    @(negedge clk);
    checks++; if (port_ack !== 8'h04) begin errors++; $display("FAIL alias write ack: got %h want 04", port_ack); end
    next_cyc(); clr(); mem_m[16] = 16'hBEEF;
    set_port(5, 0, 1, 16'h0010, 16'h0);
    @(negedge clk);
    checks++; if (port_ack !== 8'h20) begin errors++; $display("FAIL alias read ack: got %h want 20", port_ack); end
    next_cyc();
    set_port(5, 0, 1, 16'h0410, 16'h0);
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h20) begin errors++; $display("FAIL alias rvalid: got %h want 20", port_rvalid); end
    checks++; if (port_rdata !== 16'hBEEF) begin errors++; $display("FAIL alias rdata: got %h want beef", port_rdata); end
    next_cyc(); clr();
    @(negedge clk);
    checks++; if (port_rdata !== 16'hBEEF) begin errors++; $display("FAIL alias 0x0410 rdata: got %h want beef", port_rdata); end
    next_cyc();
  endtask

  task automatic test_dev_stall;
    do_reset();
    set_port(3, 1, 0, 16'hFC05, 16'hA5A5);
    set_port(5, 0, 1, 16'h0001, 16'h0);
    set_port(6, 0, 1, 16'h0002, 16'h0);
    for (int c = 0; c < 4; c++) begin
      dev_ready = (c == 3);
      @(negedge clk);
      checks++; if (dev_wren !== 1'b1) begin errors++; $display("FAIL stall dev_wren c%0d: got %b want 1", c, dev_wren); end
      checks++; if (dev_addr !== 10'h005) begin errors++; $display("FAIL stall dev_addr c%0d: got %h want 005", c, dev_addr); end
      checks++; if (dev_core_id !== 4'd3) begin errors++; $display("FAIL stall core_id c%0d: got %0d want 3", c, dev_core_id); end
      checks++; if (port_grant !== 8'h08) begin errors++; $display("FAIL stall grant c%0d: got %h want 08", c, port_grant); end
      checks++; if (port_ack !== ((c == 3) ? 8'h08 : 8'h00)) begin errors++; $display("FAIL stall ack c%0d: got %h want %h", c, port_ack, (c == 3) ? 8'h08 : 8'h00); end
      next_cyc();
    end
    set_port(3, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (port_grant !== 8'h20) begin errors++; $display("FAIL stall next grant: got %h want 20", port_grant); end
    checks++; if (dev_wren !== 1'b0) begin errors++; $display("FAIL stall dev_wren after: got %b want 0", dev_wren); end
    next_cyc(); clr(); rr_m = 6;
  endtask

  task automatic test_dev_read;
    set_port(1, 0, 1, 16'hFFFF, 16'h0);
    @(negedge clk);
    checks++; if (dev_rden !== 1'b1) begin errors++; $display("FAIL devrd dev_rden: got %b want 1", dev_rden); end
    checks++; if (dev_addr !== 10'h3FF) begin errors++; $display("FAIL devrd dev_addr: got %h want 3ff", dev_addr); end
    checks++; if (port_ack !== 8'h02) begin errors++; $display("FAIL devrd ack: got %h want 02", port_ack); end
    next_cyc(); clr(); dev_rdata = 16'h1234;
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h02) begin errors++; $display("FAIL devrd rvalid: got %h want 02", port_rvalid); end
    checks++; if (port_rdata !== 16'h1234) begin errors++; $display("FAIL devrd rdata: got %h want 1234", port_rdata); end
    clr(); next_cyc(); rr_m = 2;
  endtask

  task automatic test_wr_and_rd;
    set_port(4, 1, 1, 16'h0020, 16'h5A5A);
    @(negedge clk);
    checks++; if (port_ack !== 8'h10) begin errors++; $display("FAIL wrrd ack: got %h want 10", port_ack); end
    next_cyc(); clr(); mem_m[32] = 16'h5A5A;
    set_port(4, 0, 1, 16'h0020, 16'h0);
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h00) begin errors++; $display("FAIL wrrd no rvalid: got %h want 00", port_rvalid); end
    next_cyc(); clr();
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h10) begin errors++; $display("FAIL wrrd readback rvalid: got %h want 10", port_rvalid); end
    checks++; if (port_rdata !== 16'h5A5A) begin errors++; $display("FAIL wrrd readback rdata: got %h want 5a5a", port_rdata); end
    next_cyc(); rr_m = 5;
  endtask

`ifdef SHARED_MEM_LOCK_EN
  task automatic test_lock;
    do_reset();
    port_lock[4] = 1'b1;
    set_port(4, 0, 1, 16'h0003, 16'h0);
    @(negedge clk);
    checks++; if (port_ack !== 8'h10) begin errors++; $display("FAIL lock first ack: got %h want 10", port_ack); end
    next_cyc();
    set_port(4, 0, 0, 16'h0, 16'h0);
    set_port(0, 0, 1, 16'h0001, 16'h0);
    set_port(1, 0, 1, 16'h0002, 16'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (port_grant !== 8'h10) begin errors++; $display("FAIL lock idle grant c%0d: got %h want 10", c, port_grant); end
      checks++; if (port_ack !== 8'h00) begin errors++; $display("FAIL lock idle ack c%0d: got %h want 00", c, port_ack); end
      next_cyc();
    end
    set_port(4, 1, 0, 16'h0040, 16'h1111);
    @(negedge clk);
    checks++; if (port_ack !== 8'h10) begin errors++; $display("FAIL lock write ack: got %h want 10", port_ack); end
    next_cyc();
    set_port(4, 0, 0, 16'h0, 16'h0);
    port_lock[4] = 1'b0;
    @(negedge clk);
    checks++; if (port_grant !== 8'h01) begin errors++; $display("FAIL lock release grant: got %h want 01", port_grant); end
    checks++; if (port_ack !== 8'h01) begin errors++; $display("FAIL lock release ack: got %h want 01", port_ack); end
    clr(); next_cyc();
  endtask
`endif

  task automatic test_reset_stall;
    do_reset();
    set_port(1, 0, 1, 16'hFFFF, 16'h0);
    dev_ready = 1'b0;
    @(negedge clk);
    checks++; if ({dev_rden, port_ack} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rststall stalled: got %b/%h want 1/00", dev_rden, port_ack); end
    next_cyc();
    reset = 1'b1; clr();
    #1;
    checks++; if ({port_grant, port_ack, port_rvalid} !== 24'h0) begin errors++; $display("FAIL rststall ports: got %h/%h/%h want 0", port_grant, port_ack, port_rvalid); end
    checks++; if ({dev_wren, dev_rden, dev_core_id} !== 6'h0) begin errors++; $display("FAIL rststall dev: got %b%b/%h want 0", dev_wren, dev_rden, dev_core_id); end
    next_cyc(); reset = 1'b0; rr_m = 0;
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h00) begin errors++; $display("FAIL rststall rvalid after: got %h want 00", port_rvalid); end
    next_cyc();
    // Memory read acked just before reset: its rvalid must not survive.
    set_port(2, 0, 1, 16'h0010, 16'h0);
    next_cyc();
    clr(); reset = 1'b1;
    #1;
    checks++; if (port_rvalid !== 8'h00) begin errors++; $display("FAIL rststall pending rvalid: got %h want 00", port_rvalid); end
    next_cyc(); reset = 1'b0; rr_m = 0;
    @(negedge clk);
    checks++; if (port_rvalid !== 8'h00) begin errors++; $display("FAIL rststall rvalid released: got %h want 00", port_rvalid); end
    next_cyc();
  endtask

  task automatic test_random;
    bit            act [NP];
    bit            tw  [NP];
    bit            tr  [NP];
    logic [AW-1:0] ta  [NP];
    logic [DW-1:0] td  [NP];
    bit            pv, pdev, dsel, eack;
    int            pp, g;
    logic [DW-1:0] pd, d;
    logic [NP-1:0] egnt;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      d = 16'($urandom);
      set_port(0, 1, 0, 16'(k), d);
      next_cyc();
      mem_m[k] = d;
    end
    clr(); rr_m = 1;
    for (int p = 0; p < NP; p++) act[p] = 0;
    pv = 0; pp = 0; pd = '0; pdev = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (!act[p] && $urandom_range(0, 1) == 1) begin
          act[p] = 1;
          g = int'($urandom_range(0, 3));
          tw[p] = (g == 0) || (g == 3);
          tr[p] = (g != 0);
          if ($urandom_range(0, 3) == 0) ta[p] = 16'hFC00 | 16'($urandom_range(0, 1023));
          else begin ta[p] = 16'($urandom); ta[p][9:4] = 6'h0; end
          td[p] = 16'($urandom);
        end
        set_port(p, act[p] & tw[p], act[p] & tr[p], ta[p], td[p]);
      end
      dev_ready = ($urandom_range(0, 2) != 0);
      dev_rdata = 16'($urandom);
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NP; k++)
        if (g < 0 && act[(rr_m + k) % NP]) g = (rr_m + k) % NP;
      egnt = (g < 0) ? 8'h00 : 8'(1) << g;
      dsel = (g >= 0) && (ta[g][15:10] == 6'h3F);
      eack = (g >= 0) && (!dsel || dev_ready);
      checks++; if (port_grant !== egnt) begin errors++; $display("FAIL rand grant cyc%0d: got %h want %h", cyc, port_grant, egnt); end
      checks++; if (port_ack !== (eack ? egnt : 8'h00)) begin errors++; $display("FAIL rand ack cyc%0d: got %h want %h", cyc, port_ack, eack ? egnt : 8'h00); end
      checks++; if (dev_wren !== (dsel && tw[g])) begin errors++; $display("FAIL rand dev_wren cyc%0d: got %b", cyc, dev_wren); end
      checks++; if (dev_rden !== (dsel && tr[g] && !tw[g])) begin errors++; $display("FAIL rand dev_rden cyc%0d: got %b", cyc, dev_rden); end
      checks++; if (port_rvalid !== (pv ? 8'(1) << pp : 8'h00)) begin errors++; $display("FAIL rand rvalid cyc%0d: got %h want %h", cyc, port_rvalid, pv ? 8'(1) << pp : 8'h00); end
      if (pv) begin
        checks++; if (port_rdata !== (pdev ? dev_rdata : pd)) begin errors++; $display("FAIL rand rdata cyc%0d: got %h want %h", cyc, port_rdata, pdev ? dev_rdata : pd); end
      end
      pv = 0;
      if (eack) begin
        if (tr[g] && !tw[g]) begin pv = 1; pp = g; pdev = dsel; pd = mem_m[ta[g][9:0]]; end
        if (tw[g] && !dsel) mem_m[ta[g][9:0]] = td[g];
        rr_m = (g + 1) % NP;
        act[g] = 0;
      end
      next_cyc();
    end
    clr(); next_cyc();
  endtask

  initial begin
    test_reset();
    test_all_read();
    test_alias();
    test_dev_stall();
    test_dev_read();
    test_wr_and_rd();
`ifdef SHARED_MEM_LOCK_EN
    test_lock();
`endif
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
